alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one instance of the team's 32-bit `alu` between two independent requesters, such as the fetch/branch unit and the execute unit.
Each requester gets a valid/ready request channel and a valid/ready response channel. A round-robin arbiter grants the ALU, and the block registers the operands and each requester's result and flags.
One operation completes every 2 cycles; results are buffered per requester so backpressure on one side never blocks the other.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the `alu` DATA_WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_A  input  DATA_WIDTH  operand A
req0_B  input  DATA_WIDTH  operand B
req0_ALUop  input  3  ALU opcode (AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111)
resp0_valid  output  1  result slot 0 full
resp0_ready  input  1  requester 0 consumes result
resp0_Result  output  DATA_WIDTH  registered ALU Result
resp0_flags  output  3  registered {Overflow, CarryOut, Zero}
req1_valid, req1_ready, req1_A, req1_B, req1_ALUop  same widths and meaning as requester 0
resp1_valid, resp1_ready, resp1_Result, resp1_flags  same widths and meaning as requester 0

Behaviour:
- Reset: state=IDLE, rr_last=1 (requester 0 wins first tie), operand registers=0, resp0/1_valid=0, resp0/1_Result=0, resp0/1_flags=0.
- A requester N is eligible when reqN_valid=1 and its response slot is free or draining, i.e. (respN_valid==0 || respN_ready).
- State IDLE:
  - grant the eligible requester; if both are eligible, grant the one != rr_last.
  - reqN_ready = (state==IDLE) && granted==N. It is combinational from valid; at most one ready is high.
  - On handshake: latch A, B, ALUop and the owner id; set rr_last=N; go to EXEC.
  - No eligible requester: stay in IDLE.
- State EXEC:
  - The `alu` sees the registered operands.
  - At the end of the cycle: respN_Result <= Result, respN_flags <= {Overflow, CarryOut, Zero}, respN_valid <= 1 for the owner; return to IDLE.
- Latency: handshake at edge E0 gives respN_valid=1 after edge E1. Throughput is 1 operation per 2 cycles.
- Response slot: respN_valid clears on the edge where respN_ready=1, unless the same edge writes a new result, in which case it stays 1.
  - Outputs hold stable while respN_valid=1 and respN_ready=0.
- Requester protocol: reqN_valid and the operands must stay stable until reqN_ready. The block never accepts while state==EXEC.
- Blocked requester: a requester with a full, non-draining slot is skipped. The other requester is granted even if it was rr_last. rr_last updates only on an actual grant.
- rst asserted in EXEC: the in-flight operation is discarded, no response is produced, and all outputs return to reset values.
- rst dominates all other inputs.
- Flags and result come from `alu` unmodified: SUB CarryOut is the borrow, SLT/SLTU return 0/1 in bit 0, and Zero reflects Result.

Decomposition:
- Shared package/header:
  - ALUop code constants (AND, OR, ADD, SUB, SLT, SLTU, XOR, NOR)
  - DATA_WIDTH define
  - state encodings IDLE=1'b0, EXEC=1'b1
- Sub-module: existing `alu`, instantiated once, fed from the operand registers.
- The arbiter grant logic stays inline; it is small.

Test Plan:
- After reset, req0 ADD A=5 B=3 -> req0_ready=1 in cycle 0; resp0_valid=1 next cycle with Result=8, flags=3'b000.
- req1 SUB A=3 B=5 -> resp1_Result=0xFFFFFFFE, flags=3'b010 (CarryOut/borrow=1).
- Both valid right after reset (req0 ADD 0x7FFFFFFF+1, req1 SLT 0xFFFFFFFF vs 1):
  - req0 is granted first: Result=0x80000000, flags=3'b100.
  - req1 is granted 2 cycles later: Result=1.
  - A third tie is granted to req0 again (round-robin alternation).
- Backpressure: resp0 full and resp0_ready=0, req0 and req1 both valid -> req0_ready stays 0, req1 is served, resp0 data is unchanged. Raising resp0_ready then grants req0.
- Simultaneous drain: resp0_valid=1 with resp0_ready=1 at the same edge as a req0 handshake -> resp0_valid drops for exactly one cycle, then the new result appears.
- rst pulsed during EXEC of a req1 XOR -> resp1_valid never rises, all outputs are 0, and the next req1 operation completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and the ALU it wraps.
package alu_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. CarryOut is the carry for ADD and the borrow for SUB/SLT/SLTU;
// Overflow is signed overflow of the add or subtract; Zero reflects Result.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int MSB = DATA_WIDTH - 1;

  logic        [DATA_WIDTH:0]   sum;
  logic        [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic                         add_ovf;
  logic                         sub_ovf;
  logic                         slt;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign a_s     = A;
  assign b_s     = B;
  assign add_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
  assign sub_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
  assign slt     = a_s < b_s;

  always_comb begin
    Result   = '0;
    CarryOut = 1'b0;
    Overflow = 1'b0;
    case (ALUop)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_XOR: Result = A ^ B;
      ALU_NOR: Result = ~(A | B);
      ALU_ADD: begin
        Result   = sum[MSB:0];
        CarryOut = sum[DATA_WIDTH];
        Overflow = add_ovf;
      end
      ALU_SUB: begin
        Result   = diff[MSB:0];
        CarryOut = diff[DATA_WIDTH];
        Overflow = sub_ovf;
      end
      ALU_SLT: begin
        Result   = {{(DATA_WIDTH-1){1'b0}}, slt};
        CarryOut = diff[DATA_WIDTH];
        Overflow = sub_ovf;
      end
      default: begin
        Result   = {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH]};
        CarryOut = diff[DATA_WIDTH];
        Overflow = sub_ovf;
      end
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// registered result slot per requester so one side's backpressure never stalls the other.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_ALUop,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_Result,
  output logic [2:0]            resp0_flags,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_ALUop,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_Result,
  output logic [2:0]            resp1_flags
);

  state_e                state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [2:0]            op_q, op_d;

  logic                  resp0_valid_q, resp0_valid_d;
  logic [DATA_WIDTH-1:0] resp0_result_q, resp0_result_d;
  logic [2:0]            resp0_flags_q, resp0_flags_d;
  logic                  resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0] resp1_result_q, resp1_result_d;
  logic [2:0]            resp1_flags_q, resp1_flags_d;

  logic                  elig0, elig1;
  logic                  gnt_valid, gnt_id;
  logic                  wr0, wr1;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ovf, alu_cout, alu_zero;
  logic [2:0]            alu_flags;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .A        (opa_q),
    .B        (opb_q),
    .ALUop    (op_q),
    .Result   (alu_result),
    .Overflow (alu_ovf),
    .CarryOut (alu_cout),
    .Zero     (alu_zero)
  );

  assign alu_flags = {alu_ovf, alu_cout, alu_zero};

  // A requester whose slot is full and not draining is skipped, even if it is due its turn.
  always_comb begin
    elig0     = req0_valid && (!resp0_valid_q || resp0_ready);
    elig1     = req1_valid && (!resp1_valid_q || resp1_ready);
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE) begin
      if (elig0 && elig1) begin
        gnt_valid = 1'b1;
        gnt_id    = ~rr_last_q;
      end else if (elig0) begin
        gnt_valid = 1'b1;
      end else if (elig1) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid && gnt_id;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d   = EXEC;
          rr_last_d = gnt_id;
          owner_d   = gnt_id;
          opa_d     = gnt_id ? req1_A : req0_A;
          opb_d     = gnt_id ? req1_B : req0_B;
          op_d      = gnt_id ? req1_ALUop : req0_ALUop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write in the same cycle as a drain keeps the slot full.
  always_comb begin
    wr0 = (state_q == EXEC) && !owner_q;
    wr1 = (state_q == EXEC) && owner_q;

    resp0_valid_d  = resp0_valid_q;
    resp0_result_d = resp0_result_q;
    resp0_flags_d  = resp0_flags_q;
    if (resp0_ready) resp0_valid_d = 1'b0;
    if (wr0) begin
      resp0_valid_d  = 1'b1;
      resp0_result_d = alu_result;
      resp0_flags_d  = alu_flags;
    end

    resp1_valid_d  = resp1_valid_q;
    resp1_result_d = resp1_result_q;
    resp1_flags_d  = resp1_flags_q;
    if (resp1_ready) resp1_valid_d = 1'b0;
    if (wr1) begin
      resp1_valid_d  = 1'b1;
      resp1_result_d = alu_result;
      resp1_flags_d  = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_last_q      <= 1'b1;
      owner_q        <= 1'b0;
      opa_q          <= '0;
      opb_q          <= '0;
      op_q           <= '0;
      resp0_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp0_flags_q  <= '0;
      resp1_valid_q  <= 1'b0;
      resp1_result_q <= '0;
      resp1_flags_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_last_q      <= rr_last_d;
      owner_q        <= owner_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      op_q           <= op_d;
      resp0_valid_q  <= resp0_valid_d;
      resp0_result_q <= resp0_result_d;
      resp0_flags_q  <= resp0_flags_d;
      resp1_valid_q  <= resp1_valid_d;
      resp1_result_q <= resp1_result_d;
      resp1_flags_q  <= resp1_flags_d;
    end
  end

  assign resp0_valid  = resp0_valid_q;
  assign resp0_Result = resp0_result_q;
  assign resp0_flags  = resp0_flags_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp1_Result = resp1_result_q;
  assign resp1_flags  = resp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus arbitration, backpressure and reset sequences,
// with per-requester scoreboards checked whenever a response is consumed.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [2:0]  rop [2];
  logic [1:0]  sready;
  logic [1:0]  rdy;
  logic [1:0]  svld;
  logic [31:0] res0, res1;
  logic [2:0]  flg0, flg1;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (rv[0]),
    .req0_ready   (rdy[0]),
    .req0_A       (ra[0]),
    .req0_B       (rb[0]),
    .req0_ALUop   (rop[0]),
    .resp0_valid  (svld[0]),
    .resp0_ready  (sready[0]),
    .resp0_Result (res0),
    .resp0_flags  (flg0),
    .req1_valid   (rv[1]),
    .req1_ready   (rdy[1]),
    .req1_A       (ra[1]),
    .req1_B       (rb[1]),
    .req1_ALUop   (rop[1]),
    .resp1_valid  (svld[1]),
    .resp1_ready  (sready[1]),
    .resp1_Result (res1),
    .resp1_flags  (flg1)
  );

  function automatic exp_t mk(input logic [31:0] r, input logic [2:0] f);
    exp_t e;
    e.r = r;
    e.f = f;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int n, input exp_t e);
    if (n == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rv[n]  = 1'b1;
    rop[n] = op;
    ra[n]  = a;
    rb[n]  = b;
  endtask

  // Waits (bounded) for the grant, records the expectation, then drops valid after the edge.
  task automatic wait_hs(input int n, input exp_t e);
    int k;
    k = 0;
    @(negedge clk);
    while (!rdy[n] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("req%0d_ready_handshake", n), 64'(rdy[n]), 64'd1);
    if (rdy[n]) push(n, e);
    @(posedge clk);
    #1 rv[n] = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q0.size() + q1.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (svld[0] && sready[0]) begin
        check("resp0_expected_pending", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          exp_t e;
          e = q0.pop_front();
          check("resp0_Result", 64'(res0), 64'(e.r));
          check("resp0_flags", 64'(flg0), 64'(e.f));
        end
      end
      if (svld[1] && sready[1]) begin
        check("resp1_expected_pending", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          exp_t e;
          e = q1.pop_front();
          check("resp1_Result", 64'(res1), 64'(e.r));
          check("resp1_flags", 64'(flg1), 64'(e.f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, ALU_ADD,  32'd5,        32'd3,        32'd8,        3'b000};
    tbl[1]  = '{1, ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 3'b010};
    tbl[2]  = '{0, ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 3'b000};
    tbl[3]  = '{1, ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 3'b000};
    tbl[4]  = '{0, ALU_XOR,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 3'b001};
    tbl[5]  = '{1, ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b000};
    tbl[6]  = '{0, ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        3'b010};
    tbl[7]  = '{1, ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        3'b000};
    tbl[8]  = '{0, ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        3'b011};
    tbl[9]  = '{1, ALU_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 3'b100};
    tbl[10] = '{0, ALU_SUB,  32'd7,        32'd7,        32'd0,        3'b001};
    tbl[11] = '{1, ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'd0,        3'b111};

    rst    = 1'b1;
    rv     = 2'b00;
    sready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ra[i]  = '0;
      rb[i]  = '0;
      rop[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_resp_valid", 64'(svld), 64'd0);
    check("reset_resp0_Result", 64'(res0), 64'd0);
    check("reset_resp1_Result", 64'(res1), 64'd0);
    check("reset_flags", 64'({flg0, flg1}), 64'd0);
    check("reset_req_ready", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;

    // First-transaction latency: ready in cycle 0, result visible after the next edge.
    drive(0, ALU_ADD, 32'd5, 32'd3);
    @(negedge clk);
    check("lat_req0_ready_cycle0", 64'(rdy[0]), 64'd1);
    push(0, mk(32'd8, 3'b000));
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    check("lat_resp0_valid_exec", 64'(svld[0]), 64'd0);
    @(negedge clk);
    check("lat_resp0_valid_done", 64'(svld[0]), 64'd1);
    check("lat_resp0_Result", 64'(res0), 64'd8);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b);
      wait_hs(tbl[i].sel, mk(tbl[i].res, tbl[i].flg));
    end
    wait_drain();

    // Tie straight after reset: requester 0 first, then 1, then 0 again on the next tie.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, ALU_ADD, 32'h7FFFFFFF, 32'd1);
    drive(1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    check("tie1_req0_ready", 64'(rdy[0]), 64'd1);
    check("tie1_req1_ready", 64'(rdy[1]), 64'd0);
    push(0, mk(32'h80000000, 3'b100));
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    check("tie1_exec_no_ready", 64'(rdy), 64'd0);
    @(negedge clk);
    check("tie1_req1_ready_later", 64'(rdy[1]), 64'd1);
    push(1, mk(32'd1, 3'b000));
    @(posedge clk);
    #1 rv[1] = 1'b0;
    drive(0, ALU_AND, 32'd3, 32'd1);
    drive(1, ALU_OR, 32'd0, 32'd0);
    @(negedge clk);
    check("tie2_exec_no_ready", 64'(rdy), 64'd0);
    @(negedge clk);
    check("tie2_req0_ready", 64'(rdy[0]), 64'd1);
    check("tie2_req1_ready", 64'(rdy[1]), 64'd0);
    push(0, mk(32'd1, 3'b000));
    @(posedge clk);
    #1 rv[0] = 1'b0;
    wait_hs(1, mk(32'd0, 3'b001));
    wait_drain();

    // Backpressure on slot 0, then a drain on the same edge as a new requester-0 grant.
    sready[0] = 1'b0;
    drive(0, ALU_ADD, 32'd10, 32'd20);
    wait_hs(0, mk(32'd30, 3'b000));
    @(negedge clk);
    @(negedge clk);
    check("bp_resp0_full", 64'(svld[0]), 64'd1);
    @(posedge clk);
    #1;
    drive(0, ALU_SUB, 32'd100, 32'd1);
    drive(1, ALU_XOR, 32'h000000FF, 32'h0000000F);
    @(negedge clk);
    check("bp_req0_blocked", 64'(rdy[0]), 64'd0);
    check("bp_req1_served", 64'(rdy[1]), 64'd1);
    push(1, mk(32'h000000F0, 3'b000));
    @(posedge clk);
    #1 rv[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req0_still_blocked", 64'(rdy[0]), 64'd0);
      check("bp_resp0_held_valid", 64'(svld[0]), 64'd1);
      check("bp_resp0_held_Result", 64'(res0), 64'd30);
    end
    @(posedge clk);
    #1 sready[0] = 1'b1;
    @(negedge clk);
    check("drain_req0_granted", 64'(rdy[0]), 64'd1);
    push(0, mk(32'd99, 3'b000));
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    check("drain_resp0_gap", 64'(svld[0]), 64'd0);
    @(negedge clk);
    check("drain_resp0_new_valid", 64'(svld[0]), 64'd1);
    check("drain_resp0_new_Result", 64'(res0), 64'd99);
    wait_drain();

    // Reset while a requester-1 XOR is executing: it must vanish without a response.
    drive(1, ALU_XOR, 32'd1, 32'd2);
    @(negedge clk);
    check("rst_exec_req1_ready", 64'(rdy[1]), 64'd1);
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_exec_resp_valid", 64'(svld), 64'd0);
    check("rst_exec_resp0_Result", 64'(res0), 64'd0);
    check("rst_exec_resp1_Result", 64'(res1), 64'd0);
    check("rst_exec_flags", 64'({flg0, flg1}), 64'd0);
    check("rst_exec_req_ready", 64'(rdy), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_exec_resp1_stays_low", 64'(svld[1]), 64'd0);
    end
    @(posedge clk);
    #1;
    drive(1, ALU_ADD, 32'd2, 32'd2);
    wait_hs(1, mk(32'd4, 3'b000));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
